// File: rtl/apb_regfile_completer.sv
// ---------------------------------------------------------------------------
// apb_regfile_completer
//
// APB completer holding DEPTH 8-bit registers. Every transfer is stretched by
// WAIT_CYCLES wait states (access-phase cycles with pready low), so the
// completion edge lands WAIT_CYCLES+2 cycles after the setup cycle.
// Addresses at or above DEPTH are out of range: reads return 0x00 and writes
// are discarded.
//
// Optional feature (compile-time macro APB_COMPLETER_PSLVERR_EN):
//   defined   - pslverr is high in the pready-high cycle of an out-of-range
//               transfer
//   undefined - pslverr is tied low
//
// Parameters:
//   DEPTH       number of registers, 1..256
//   WAIT_CYCLES wait states per transfer, 0..15
//
// Ports:
//   pclk     in   bus clock, rising edge
//   prstn    in   asynchronous reset, active HIGH despite its name
//   psel     in   completer select
//   penable  in   access-phase strobe
//   pwrite   in   1 = write, 0 = read (captured in the setup cycle)
//   paddr    in   8-bit register address (captured in the setup cycle)
//   pwdata   in   8-bit write data (captured in the setup cycle)
//   prdata   out  read data, valid while pready is high on a read
//   pready   out  registered transfer-complete
//   pslverr  out  registered error response
// ---------------------------------------------------------------------------
module apb_regfile_completer #(
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic       pclk,
    input  logic       prstn,
    input  logic       psel,
    input  logic       penable,
    input  logic       pwrite,
    input  logic [7:0] paddr,
    input  logic [7:0] pwdata,
    output logic [7:0] prdata,
    output logic       pready,
    output logic       pslverr
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // IDLE watches for a setup cycle; SETUP is the first access cycle after
    // the request was captured; ACCESS covers the remaining access cycles.
    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  regs [DEPTH];
    logic [7:0]  addr_q;
    logic [7:0]  addr_next;
    logic [7:0]  wdata_q;
    logic [7:0]  wdata_next;
    logic        write_q;
    logic        write_next;
    logic [3:0]  count;
    logic [3:0]  count_next;
    logic [7:0]  prdata_next;
    logic        load_ready;
    logic        complete;
    logic        commit;
    logic        wr_in_range;
    logic [7:0]  rd_addr;
    logic        rd_write;
    logic        rd_in_range;
    logic [7:0]  rd_data;

    // A transfer finishes when the master is still in the access phase and
    // pready is already high; only in-range writes touch the register file.
    assign complete    = (state != IDLE) && psel && penable && pready;
    assign wr_in_range = ({1'b0, addr_q} < 9'(DEPTH));
    assign commit      = complete && write_q && wr_in_range;

    // pready rises on the same edge that leaves IDLE when there are no wait
    // states, before addr_q/write_q are loaded, so the read lookup takes the
    // live bus values in IDLE and the captured ones afterwards.
    assign rd_addr     = (state == IDLE) ? paddr  : addr_q;
    assign rd_write    = (state == IDLE) ? pwrite : write_q;
    assign rd_in_range = ({1'b0, rd_addr} < 9'(DEPTH));
    assign rd_data     = rd_in_range ? regs[rd_addr[IDX_W-1:0]] : 8'h00;

    // State register plus the captured request, counter and registered
    // outputs. pready is high for exactly one cycle per completed transfer,
    // so it simply follows load_ready.
    always_ff @(posedge pclk or posedge prstn) begin
        if (prstn) begin
            state   <= IDLE;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
            write_q <= 1'b0;
            count   <= 4'd0;
            prdata  <= 8'h00;
            pready  <= 1'b0;
        end else begin
            state   <= state_next;
            addr_q  <= addr_next;
            wdata_q <= wdata_next;
            write_q <= write_next;
            count   <= count_next;
            prdata  <= prdata_next;
            pready  <= load_ready;
        end
    end

    // Next-state logic. The counter starts at WAIT_CYCLES and pready is
    // scheduled on the edge where it steps from 1 to 0, which puts pready
    // in access cycle WAIT_CYCLES+1. Completion or a dropped psel/penable
    // returns to IDLE, where a back-to-back setup is picked up at once.
    always_comb begin
        state_next  = state;
        addr_next   = addr_q;
        wdata_next  = wdata_q;
        write_next  = write_q;
        count_next  = count;
        load_ready  = 1'b0;
        prdata_next = prdata;
        case (state)
            IDLE: begin
                if (psel && !penable) begin
                    state_next = SETUP;
                    addr_next  = paddr;
                    wdata_next = pwdata;
                    write_next = pwrite;
                    count_next = 4'(WAIT_CYCLES);
                    load_ready = (WAIT_CYCLES == 0);
                end
            end
            SETUP, ACCESS: begin
                if (complete || !(psel && penable)) begin
                    state_next = IDLE;
                end else begin
                    state_next = ACCESS;
                    if (count != 4'd0) begin
                        count_next = count - 4'd1;
                    end
                    load_ready = (count == 4'd1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (load_ready && !rd_write) begin
            prdata_next = rd_data;
        end
    end

    // Register file; a write lands on its completion edge, so a following
    // setup already sees the new contents.
    always_ff @(posedge pclk or posedge prstn) begin
        if (prstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= 8'h00;
            end
        end else if (commit) begin
            regs[addr_q[IDX_W-1:0]] <= wdata_q;
        end
    end

`ifdef APB_COMPLETER_PSLVERR_EN
    // Error flag shares pready's one-cycle window.
    always_ff @(posedge pclk or posedge prstn) begin
        if (prstn) begin
            pslverr <= 1'b0;
        end else begin
            pslverr <= load_ready && !rd_in_range;
        end
    end
`else
    assign pslverr = 1'b0;
`endif

endmodule

// File: tb/tb_apb_regfile_completer.sv
// ---------------------------------------------------------------------------
// tb_apb_regfile_completer
//
// Two completers share clock and reset: instance 0 with two wait states,
// instance 1 with none, both sixteen registers deep. The bench keeps its own
// register image per instance and derives, cycle by cycle, what pready,
// pslverr and (on read completions) prdata must be. A compare process checks
// both instances on every falling edge; directed scenarios add literal checks.
// ---------------------------------------------------------------------------
module tb_apb_regfile_completer;

    localparam int DEPTH = 16;

`ifdef APB_COMPLETER_PSLVERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       pclk;
    logic       prstn;
    logic       psel    [2];
    logic       penable [2];
    logic       pwrite  [2];
    logic [7:0] paddr   [2];
    logic [7:0] pwdata  [2];

    logic [7:0] prdata_w2;
    logic [7:0] prdata_w0;
    logic       pready_w2;
    logic       pready_w0;
    logic       pslverr_w2;
    logic       pslverr_w0;

    logic       rdy [2];
    logic [7:0] rd  [2];
    logic       err [2];

    assign rdy[0] = pready_w2;
    assign rdy[1] = pready_w0;
    assign rd[0]  = prdata_w2;
    assign rd[1]  = prdata_w0;
    assign err[0] = pslverr_w2;
    assign err[1] = pslverr_w0;

    // Model state: register images and the per-cycle expectation.
    logic [7:0] mem [2][256];
    logic       exp_pready [2];
    logic       exp_err    [2];
    logic       exp_chk_rd [2];
    logic [7:0] exp_rdata  [2];

    int         last_lat   [2];
    logic [7:0] last_rdata [2];
    logic       last_err   [2];

    int tests;
    int failures;
    bit cmp_on;

    apb_regfile_completer #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) u_w2 (
        .pclk    (pclk),
        .prstn   (prstn),
        .psel    (psel[0]),
        .penable (penable[0]),
        .pwrite  (pwrite[0]),
        .paddr   (paddr[0]),
        .pwdata  (pwdata[0]),
        .prdata  (prdata_w2),
        .pready  (pready_w2),
        .pslverr (pslverr_w2)
    );

    apb_regfile_completer #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) u_w0 (
        .pclk    (pclk),
        .prstn   (prstn),
        .psel    (psel[1]),
        .penable (penable[1]),
        .pwrite  (pwrite[1]),
        .paddr   (paddr[1]),
        .pwdata  (pwdata[1]),
        .prdata  (prdata_w0),
        .pready  (pready_w0),
        .pslverr (pslverr_w0)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    function automatic int waitOf(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clearExp(input int d);
        exp_pready[d] = 1'b0;
        exp_err[d]    = 1'b0;
        exp_chk_rd[d] = 1'b0;
        exp_rdata[d]  = 8'h00;
    endtask

    task automatic clearModel();
        for (int d = 0; d < 2; d++) begin
            for (int a = 0; a < 256; a++) begin
                mem[d][a] = 8'h00;
            end
            clearExp(d);
        end
    endtask

    // Every falling edge, both instances against the model.
    always @(negedge pclk) begin
        if (cmp_on) begin
            for (int d = 0; d < 2; d++) begin
                checkOutput($sformatf("pready[%0d]", d), {7'b0, rdy[d]}, {7'b0, exp_pready[d]});
                checkOutput($sformatf("pslverr[%0d]", d), {7'b0, err[d]}, {7'b0, exp_err[d]});
                if (exp_chk_rd[d]) begin
                    checkOutput($sformatf("prdata[%0d]", d), rd[d], exp_rdata[d]);
                end
            end
        end
    end

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge pclk); #1;
        end
    endtask

    // One APB transfer on instance d, entered and left at posedge+1. A
    // nonzero abort_at drops psel/penable in that access cycle instead.
    task automatic applyStimulus(input int d, input bit wr, input logic [7:0] addr,
                                 input logic [7:0] data, input int abort_at);
        int w;
        bit inr;
        w   = waitOf(d);
        inr = (int'(addr) < DEPTH);
        psel[d]    = 1'b1;
        penable[d] = 1'b0;
        pwrite[d]  = wr;
        paddr[d]   = addr;
        pwdata[d]  = data;
        clearExp(d);
        last_lat[d] = -1;
        for (int k = 1; k <= w + 1; k++) begin
            @(posedge pclk); #1;
            if (k == abort_at) begin
                psel[d]    = 1'b0;
                penable[d] = 1'b0;
                clearExp(d);
                @(posedge pclk); #1;
                return;
            end
            penable[d] = 1'b1;
            if (k == w + 1) begin
                exp_pready[d] = 1'b1;
                exp_err[d]    = ERR_EN && !inr;
                if (!wr) begin
                    exp_chk_rd[d] = 1'b1;
                    exp_rdata[d]  = inr ? mem[d][addr] : 8'h00;
                end
                last_rdata[d] = rd[d];
                last_err[d]   = err[d];
            end
            if (rdy[d] && last_lat[d] < 0) begin
                last_lat[d] = k;
            end
        end
        @(posedge pclk); #1;
        if (wr && inr) begin
            mem[d][addr] = data;
        end
        psel[d]    = 1'b0;
        penable[d] = 1'b0;
        clearExp(d);
    endtask

    initial begin
        tests    = 0;
        failures = 0;
        cmp_on   = 1'b0;
        for (int d = 0; d < 2; d++) begin
            psel[d]       = 1'b0;
            penable[d]    = 1'b0;
            pwrite[d]     = 1'b0;
            paddr[d]      = 8'h00;
            pwdata[d]     = 8'h00;
            last_lat[d]   = -1;
            last_rdata[d] = 8'h00;
            last_err[d]   = 1'b0;
        end
        clearModel();
        prstn = 1'b1;
        #1;
        cmp_on = 1'b1;
        checkOutput("reset_pready", {7'b0, pready_w2}, 8'h00);
        checkOutput("reset_prdata", prdata_w2, 8'h00);
        checkOutput("reset_pslverr", {7'b0, pslverr_w0}, 8'h00);
        idleCycles(2);
        prstn = 1'b0;
        idleCycles(2);

        // Write then read with two wait states.
        applyStimulus(0, 1'b1, 8'h03, 8'hA5, 0);
        checkOutput("w2_write_latency", 8'(last_lat[0]), 8'd3);
        applyStimulus(0, 1'b0, 8'h03, 8'h00, 0);
        checkOutput("w2_read_a5", last_rdata[0], 8'hA5);
        idleCycles(1);

        // No wait states: read of a fresh register.
        applyStimulus(1, 1'b0, 8'h00, 8'h00, 0);
        checkOutput("w0_read_latency", 8'(last_lat[1]), 8'd1);
        checkOutput("w0_read_zero", last_rdata[1], 8'h00);
        idleCycles(1);

        // Back-to-back write/read with no idle gap on both instances.
        for (int d = 0; d < 2; d++) begin
            applyStimulus(d, 1'b1, 8'h01, 8'h11, 0);
            applyStimulus(d, 1'b0, 8'h01, 8'h00, 0);
            checkOutput($sformatf("b2b_read[%0d]", d), last_rdata[d], 8'h11);
            idleCycles(1);
        end

        // Out-of-range write and read.
        applyStimulus(0, 1'b1, 8'h20, 8'h5A, 0);
        checkOutput("oor_write_err", {7'b0, last_err[0]}, {7'b0, ERR_EN});
        applyStimulus(0, 1'b0, 8'h20, 8'h00, 0);
        checkOutput("oor_read_data", last_rdata[0], 8'h00);
        checkOutput("oor_read_err", {7'b0, last_err[0]}, {7'b0, ERR_EN});
        idleCycles(1);

        // Abort a write during its wait states, then read the target back.
        applyStimulus(0, 1'b1, 8'h02, 8'hFF, 2);
        idleCycles(3);
        applyStimulus(0, 1'b0, 8'h02, 8'h00, 0);
        checkOutput("abort_reg2", last_rdata[0], 8'h00);
        idleCycles(1);

        // Access strobe without a setup cycle is ignored.
        psel[0]    = 1'b1;
        penable[0] = 1'b1;
        pwrite[0]  = 1'b1;
        paddr[0]   = 8'h04;
        pwdata[0]  = 8'hC3;
        idleCycles(3);
        psel[0]    = 1'b0;
        penable[0] = 1'b0;
        idleCycles(1);
        applyStimulus(0, 1'b0, 8'h04, 8'h00, 0);
        checkOutput("stray_penable_reg4", last_rdata[0], 8'h00);
        idleCycles(1);

        // Reset asserted in the pready-high cycle of a read of 0x77.
        applyStimulus(0, 1'b1, 8'h05, 8'h77, 0);
        psel[0]    = 1'b1;
        penable[0] = 1'b0;
        pwrite[0]  = 1'b0;
        paddr[0]   = 8'h05;
        for (int k = 1; k <= 3; k++) begin
            @(posedge pclk); #1;
            penable[0] = 1'b1;
            if (k == 3) begin
                exp_pready[0] = 1'b1;
                exp_chk_rd[0] = 1'b1;
                exp_rdata[0]  = mem[0][5];
            end
        end
        checkOutput("pre_reset_prdata", prdata_w2, 8'h77);
        #2;
        prstn = 1'b1;
        #1;
        checkOutput("rst_now_pready", {7'b0, pready_w2}, 8'h00);
        checkOutput("rst_now_prdata", prdata_w2, 8'h00);
        psel[0]    = 1'b0;
        penable[0] = 1'b0;
        clearModel();
        @(posedge pclk); #3;
        prstn = 1'b0;
        @(posedge pclk); #1;
        applyStimulus(0, 1'b0, 8'h05, 8'h00, 0);
        checkOutput("post_reset_reg5", last_rdata[0], 8'h00);
        idleCycles(1);

        // Randomized traffic against the model.
        for (int n = 0; n < 300; n++) begin
            int d;
            bit wr;
            logic [7:0] addr;
            logic [7:0] data;
            int abort_at;
            d    = int'($urandom_range(0, 1));
            wr   = 1'($urandom_range(0, 1));
            addr = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(16, 255))
                                               : 8'($urandom_range(0, 15));
            data = 8'($urandom_range(0, 255));
            abort_at = 0;
            if (d == 0 && $urandom_range(0, 7) == 0) begin
                abort_at = int'($urandom_range(1, 2));
            end
            applyStimulus(d, wr, addr, data, abort_at);
            idleCycles(int'($urandom_range(0, 2)));
        end

        idleCycles(2);
        cmp_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/apb_regfile_completer.md
Name: apb_regfile_completer

Overview:
- APB completer (responder) for the 8-bit APB fabric. It is the far end of the bus driven by the team's APB master.
- Holds a small register file. Completes reads and writes with a programmable number of wait states.
- Flags out-of-range accesses.
- Drop-in alternative slave on the psel/penable/pready bus inside the top-level APB subsystem.

Parameters:
- DEPTH, 16: number of 8-bit registers. Legal addresses are 0..DEPTH-1. Range 1..256.
- WAIT_CYCLES, 2: wait states inserted per transfer, i.e. access-phase cycles with pready low. Range 0..15.

Ports:
- pclk  input  1  bus clock; all state changes on its rising edge
- prstn  input  1  asynchronous, active-high reset. Asserted high clears all state immediately.
- psel  input  1  completer select from master
- penable  input  1  access-phase strobe from master
- pwrite  input  1  1 = write, 0 = read; sampled in setup phase
- paddr  input  8  register address; sampled in setup phase
- pwdata  input  8  write data; sampled in setup phase
- prdata  output  8  read data; valid while pready=1 on a read
- pready  output  1  transfer-complete indication, registered
- pslverr  output  1  error response (see Optional Feature), registered

Behaviour:
- Reset (prstn=1, async):
  - pready=0, prdata=0x00, pslverr=0.
  - All registers 0x00, wait counter 0, FSM to IDLE.
  - On deassertion, the FSM resumes from IDLE at the next pclk edge.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - psel=1 & penable=0 → SETUP. Latch paddr, pwrite, pwdata; load counter with WAIT_CYCLES.
  - penable=1 without a preceding setup cycle is ignored; stay IDLE.
- SETUP (one cycle):
  - Unconditionally → ACCESS.
  - pready is set so that it is high in the first ACCESS cycle iff WAIT_CYCLES=0.
- ACCESS, while psel=1 & penable=1:
  - Counter decrements each cycle. pready goes high in access cycle WAIT_CYCLES+1.
  - Transfer latency from setup cycle to completion edge = WAIT_CYCLES+2 cycles.
- Completion edge (psel & penable & pready):
  - Write, in range: reg[addr] <= wdata.
  - Read, in range: prdata equals reg[addr] during the pready-high cycle.
  - Out-of-range read returns 0x00. Out-of-range write is discarded.
  - Next cycle: pready=0, pslverr=0.
  - If psel=1 & penable=0 → SETUP (back-to-back transfer, no idle gap); else → IDLE.
- psel or penable dropped during ACCESS before completion:
  - Abort to IDLE, pready forced 0, no register write.
- prdata holds its last driven value outside read completions; masters must not sample it then.
- Read-after-write to the same address returns the new data. The write commits on completion, before the next setup.
- Address compare is on the full 8 bits, unsigned: in range iff paddr < DEPTH. DEPTH=256 makes every address legal.
- Reset asserted mid-transfer: transfer lost, no partial write, outputs cleared immediately.

Optional Feature:
- Macro APB_COMPLETER_PSLVERR_EN.
- Defined:
  - pslverr=1 exactly in the pready-high cycle of an out-of-range transfer (read or write). 0 otherwise.
- Undefined:
  - pslverr tied 0.
  - Out-of-range transfers still complete normally: read returns 0x00, write discarded.
- Wait-state timing is identical in both builds.

Test Plan:
- Reset, then write 0xA5 to addr 0x03 with WAIT_CYCLES=2 → pready high in 3rd access cycle; a read of 0x03 then returns prdata=0xA5 with pready.
- WAIT_CYCLES=0, read addr 0x00 after reset → pready high in first access cycle, prdata=0x00, total 2 cycles.
- Back-to-back write 0x11→addr1, read addr1 with no idle gap → second setup accepted the cycle after completion; read returns 0x11.
- Write 0x5A to addr 0x20 (DEPTH=16), macro defined → pslverr=1 with pready. Re-read addr 0x20 returns 0x00, pslverr=1. Macro undefined → pslverr stays 0.
- Deassert psel during wait state of write 0xFF→addr2 → FSM to IDLE, pready never asserts, reg2 stays 0x00.
- Assert prstn mid-access after writing 0x77→addr5 → outputs clear same cycle; reg5 reads back 0x00 after release.
